// File: rtl/repadd_mult_ctrl.sv
// Unsigned multiplier controller using repeated addition through an external adder.
// Product is min(a,b) additions of max(a,b); the adder is outside this block.
module repadd_mult_ctrl #(
  parameter int unsigned OPW = 8,
  parameter int unsigned ACW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [ACW-1:0] add_in1,
  output logic [ACW-1:0] add_in2,
  input  logic [ACW-1:0] add_out,
  output logic           busy,
  output logic           done,
  output logic [ACW-1:0] product
);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  state_e         r_state;
  logic [ACW-1:0] r_acc;
  logic [ACW-1:0] r_mcand;
  logic [OPW-1:0] r_count;
  logic           r_busy;
  logic           r_done;
  logic [ACW-1:0] r_product;

  logic           w_a_lt_b;
  logic [OPW-1:0] w_min;
  logic [OPW-1:0] w_max;

  // Fewer iterations when the smaller operand drives the loop count.
  assign w_a_lt_b = (a < b);
  assign w_min    = w_a_lt_b ? a : b;
  assign w_max    = w_a_lt_b ? b : a;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_count <= w_min;
            r_mcand <= ACW'(w_max);
            r_acc   <= '0;
            if (w_min == '0) begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_product <= '0;
            end else begin
              r_state <= StAdd;
              r_busy  <= 1'b1;
            end
          end
        end
        StAdd: begin
          r_acc   <= add_out;
          r_count <= r_count - 1'b1;
          // Leave after the final add; product takes the adder result directly.
          if (r_count == OPW'(1)) begin
            r_state   <= StDone;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_product <= add_out;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign add_in1 = r_acc;
  assign add_in2 = r_mcand;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: doc/repadd_mult_ctrl.md
REPADD_MULT_CTRL -- requirements
Module: repadd_mult_ctrl

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be:
  - OPW, default 8: operand width.
  - ACW, default 16: accumulator and product width; SHALL equal 2*OPW.
REQ-003 Ports SHALL be:
  - clk  in  1  rising-edge clock.
  - rst  in  1  synchronous active-high reset.
  - start  in  1  request pulse; sampled only in IDLE.
  - a  in  OPW  unsigned operand.
  - b  in  OPW  unsigned operand.
  - add_in1  out  ACW  to external adder in1: current accumulator.
  - add_in2  out  ACW  to external adder in2: zero-extended multiplicand.
  - add_out  in  ACW  from external adder out; purely combinational, equals add_in1+add_in2 mod 2^ACW.
  - busy  out  1  high while in ADD.
  - done  out  1  single-cycle completion strobe.
  - product  out  ACW  registered result.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-005 In IDLE with start=1, the block SHALL capture the operands on that edge:
  - count <= min(a,b); mcand <= max(a,b), zero-extended to ACW; acc <= 0.
  - If a==b, either operand SHALL be used.
REQ-006 IDLE transitions on start=1 SHALL be:
  - min(a,b)==0: go to DONE with acc=0.
  - otherwise: go to ADD.
REQ-007 In ADD, each cycle SHALL perform acc <= add_out and count <= count-1.
REQ-008 The ADD exit condition SHALL be count==1 at the clock edge: move to DONE on that edge, after the final add.
REQ-009 add_in1 SHALL be acc and add_in2 SHALL be mcand, driven directly from registers with no added logic, in every state.
REQ-010 On entry to DONE, product SHALL be loaded with the final acc.
REQ-011 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always return to IDLE on the next edge.
REQ-012 busy SHALL be 1 only in ADD.
REQ-013 Latency from the start-sampling edge to done high SHALL be min(a,b)+1 cycles for nonzero operands, and 1 cycle when either operand is 0.
REQ-014 start SHALL be ignored in ADD and DONE. Operand changes outside the IDLE sampling edge SHALL have no effect.
REQ-015 product SHALL hold its value from DONE until the next DONE, including while a new operation is in ADD.
REQ-016 No overflow SHALL be possible: the maximum result (2^OPW-1)^2 fits in ACW. No overflow flag SHALL be provided.
REQ-017 Back-to-back operation SHALL be supported: start asserted in the cycle right after done (state IDLE) SHALL be accepted.

Reset
REQ-018 On any clock edge with rst=1, the block SHALL enter IDLE regardless of state, including mid-ADD.
REQ-019 Reset values SHALL be:
  - acc=0, mcand=0, count=0, product=0.
  - busy=0, done=0.
  - hence add_in1=0 and add_in2=0.
REQ-020 rst SHALL take priority over start on the same edge. No partial result SHALL be written to product.

Verification
REQ-021 a=5, b=3, start for 1 cycle -> busy high 3 cycles; done 4 cycles after start edge; product=15.
REQ-022 a=0, b=200 -> done 1 cycle after start; busy never high; product=0.
REQ-023 a=1, b=200 -> operands swap; 1 add; done after 2 cycles; product=200.
REQ-024 a=255, b=255 -> done after 256 cycles; product=65025; add_in1/add_in2 track acc/255 each cycle.
REQ-025 a=7, b=6; start pulsed again mid-ADD with a=2, b=2 -> second start ignored; product=42.
REQ-026 Run 9*9, reach product=81, start 10*10, assert rst after 3 ADD cycles:
  - next cycle: IDLE, busy=0, done=0, product=0, add_in1=0, add_in2=0.
  - then 4*4 with no intervening rst -> product=16 after 5 cycles.
